pwm_plane_driver: RTL and testbench
===================================

// Module: pwm_plane_driver
// PURPOSE
//   Parametrised multi-channel PWM driver for one LED-cube plane. Receives command (rs=1) and
//   brightness (rs=0) bytes over the byte bus, stores them in a shadow bank and copies them to
//   the active bank only at a PWM period boundary, so outputs never glitch mid-period.
//   Adds over the previous plane controller: variable channel count, counter width, prescaler,
//   double buffering, auto-commit and output enable.
// PARAMETERS
//   OUT_NUM   8   number of PWM channels (>=2)
//   D_WIDTH   8   bus width; must be >= C_WIDTH and >= 4
//   C_WIDTH   5   PWM counter width; period = 2**C_WIDTH ticks
//   PRESCALE  1   clk cycles per PWM tick (>=1); 1 = tick every clk
// PORTS
//   clk      in   1         system clock, all logic on rising edge
//   reset    in   1         asynchronous, active-low reset
//   dataIn   in   D_WIDTH   command or brightness byte
//   dataEn   in   1         write strobe, level; may stay high for many clk cycles
//   rs       in   1         1 = command, 0 = brightness data
//   pwmOut   out  OUT_NUM   registered PWM outputs
// BEHAVIOUR
//   Reset: pwmOut=0, counter=0, prescaler=0, write pointer=0, shadow/active banks=0,
//     out_en=0, auto_commit=0, commit_pending=0. Reset asserted mid-period kills output at once.
//   Strobe: dataEn registered; a write is accepted on the first clk where dataEn=1 and the
//     previous sample was 0 (rising edge). Held strobe = exactly one write. dataIn, rs sampled then.
//   Command (rs=1), bits decoded together, dataIn[D_WIDTH-1:4] ignored:
//     [0] PTR_CLR     write pointer <= 0
//     [1] COMMIT      set commit_pending
//     [2] OUT_EN      out_en <= dataIn[2] (loaded by every command)
//     [3] AUTO_COMMIT auto_commit <= dataIn[3] (loaded by every command)
//   Data (rs=0): shadow[ptr] <= dataIn[C_WIDTH-1:0] (upper bits dropped); ptr increments,
//     OUT_NUM-1 wraps to 0. If auto_commit=1 and ptr was OUT_NUM-1, commit_pending is set.
//   Tick: prescaler counts 0..PRESCALE-1, tick when it equals PRESCALE-1; counter += 1 per
//     tick, wraps 2**C_WIDTH-1 -> 0 ("wrap tick").
//   Commit: on wrap tick, if commit_pending (or a commit is being set in that same cycle),
//     active <= shadow for all channels and commit_pending <= 0. Write to shadow in the wrap
//     cycle is included in the copy. Otherwise active bank holds indefinitely.
//   Output: pwmOut[i] <= out_en & (phase_cnt_i < active[i]); 1 clk latency from counter.
//     duty 0 -> constant 0; duty 2**C_WIDTH-1 -> high (2**C_WIDTH-1)/2**C_WIDTH of period.
//     out_en=0 forces all outputs 0 on the next clk; counter keeps running.
// CONFIGURATION
//   PWM_PHASE_SHIFT_EN defined: phase_cnt_i = (counter + i*(2**C_WIDTH/OUT_NUM)) mod
//     2**C_WIDTH, spreading channel edges to cut simultaneous switching; duty unchanged;
//     commit still on base-counter wrap, so a shifted channel's period straddling a commit
//     may show one mixed old/new period.
//   Not defined: phase_cnt_i = counter for every channel; all rising edges coincide at wrap.
// STRUCTURE
//   pwm_plane_defs.vh: command bit positions (CMD_PTR_CLR=0, CMD_COMMIT=1, CMD_OUT_EN=2,
//     CMD_AUTO_COMMIT=3), RS_CMD/RS_DATA constants.
//   Sub-module pwm_channel (C_WIDTH): active duty register, phase offset add, compare and
//     output flop; instantiated OUT_NUM times via generate. Top holds strobe detect,
//     decoder, pointer, shadow bank, prescaler, counter, commit logic.
// TESTING (OUT_NUM=8, C_WIDTH=5, PRESCALE=1 unless stated)
//   1 Reset held low 10 clk, released, no writes -> pwmOut=0 for 3 full periods.
//   2 cmd 0x05, data 0x00,0x0F,0x1F,0x10, cmd 0x06 -> from next wrap: ch0 0/32, ch1 15/32,
//     ch2 31/32, ch3 16/32 high, ch4..7 0; nothing changes before that wrap.
//   3 cmd 0x05, data 0x1F x8, no COMMIT -> pwmOut stays 0 for 3 periods; cmd 0x06 -> all
//     ch 31/32 after wrap. Then cmd 0x00 -> all outputs 0 one clk after command.
//   4 cmd 0x05, data 0x01..0x09 (9 writes), cmd 0x06 -> ch0=9, ch1..ch7=2..8 (pointer wrap).
//   5 cmd 0x0D, data 0xFF x8, dataEn held 4 clk each -> exactly 8 writes, values 0x1F,
//     auto-commit at next wrap; PRESCALE=4 -> period 128 clk.
//   6 PWM_PHASE_SHIFT_EN, all ch duty 16 -> ch i rising edge offset 4*i ticks; reset pulsed
//     mid-period -> pwmOut 0 immediately, banks cleared.

Source files
------------

// File: rtl/pwm_plane_driver_pkg.sv
// Shared constants for the LED-cube plane PWM driver: command bit positions and rs encoding.
package pwm_plane_driver_pkg;

  localparam int CMD_PTR_CLR     = 0;
  localparam int CMD_COMMIT      = 1;
  localparam int CMD_OUT_EN      = 2;
  localparam int CMD_AUTO_COMMIT = 3;

  localparam logic RS_CMD  = 1'b1;
  localparam logic RS_DATA = 1'b0;

  // Index width for a counter over n states; a single-state counter still needs one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_plane_driver_channel.sv
// One PWM channel: active duty register, phase-offset compare and registered output.
// PHASE_OFS is supplied by the top (non-zero only when PWM_PHASE_SHIFT_EN is defined).
module pwm_channel #(
  parameter int C_WIDTH   = 5,
  parameter int PHASE_OFS = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               outEn,
  input  logic [C_WIDTH-1:0] dutyIn,
  input  logic [C_WIDTH-1:0] counter,
  output logic               pwmOut
);

  logic [C_WIDTH-1:0] active;
  logic [C_WIDTH-1:0] phaseCnt;

  // Addition wraps naturally modulo 2**C_WIDTH.
  assign phaseCnt = counter + C_WIDTH'(PHASE_OFS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= '0;
      pwmOut <= 1'b0;
    end else begin
      if (load) active <= dutyIn;
      pwmOut <= outEn & (phaseCnt < active);
    end
  end

endmodule

// File: rtl/pwm_plane_driver.sv
// Multi-channel PWM plane driver with shadow/active double buffering and commit on period wrap.
// Optional build macro PWM_PHASE_SHIFT_EN staggers channel phases by 2**C_WIDTH/OUT_NUM ticks.
module pwm_plane_driver
  import pwm_plane_driver_pkg::*;
#(
  parameter int OUT_NUM  = 8,
  parameter int D_WIDTH  = 8,
  parameter int C_WIDTH  = 5,
  parameter int PRESCALE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [D_WIDTH-1:0] dataIn,
  input  logic               dataEn,
  input  logic               rs,
  output logic [OUT_NUM-1:0] pwmOut
);

  localparam int PTR_W = idxWidth(OUT_NUM);
  localparam int PS_W  = idxWidth(PRESCALE);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUT_NUM - 1);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);

`ifdef PWM_PHASE_SHIFT_EN
  localparam int PHASE_STEP = (2 ** C_WIDTH) / OUT_NUM;
`else
  localparam int PHASE_STEP = 0;
`endif

  logic               dataEnQ;
  logic               writeStb, cmdWr, dataWr;
  logic [PTR_W-1:0]   ptr;
  logic               outEn, autoCommit, commitPending;
  logic               commitSet, doCommit;
  logic [PS_W-1:0]    presc;
  logic [C_WIDTH-1:0] counter;
  logic               tick, wrapTick;
  logic [C_WIDTH-1:0] shadow     [OUT_NUM];
  logic [C_WIDTH-1:0] shadowNext [OUT_NUM];
  logic               unusedBus;

  // Upper bus bits carry no meaning for commands or duties.
  assign unusedBus = ^dataIn;

  assign writeStb = dataEn & ~dataEnQ;
  assign cmdWr    = writeStb & (rs == RS_CMD);
  assign dataWr   = writeStb & (rs == RS_DATA);

  assign tick     = (presc == PS_LAST);
  assign wrapTick = tick & (counter == {C_WIDTH{1'b1}});

  assign commitSet = (cmdWr & dataIn[CMD_COMMIT])
                   | (dataWr & autoCommit & (ptr == PTR_LAST));
  assign doCommit  = wrapTick & (commitPending | commitSet);

  // A data write landing in the wrap cycle must be part of the copy, so channels load from here.
  always_comb begin
    for (int i = 0; i < OUT_NUM; i++) shadowNext[i] = shadow[i];
    if (dataWr) shadowNext[ptr] = dataIn[C_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataEnQ       <= 1'b0;
      ptr           <= '0;
      outEn         <= 1'b0;
      autoCommit    <= 1'b0;
      commitPending <= 1'b0;
      presc         <= '0;
      counter       <= '0;
      for (int i = 0; i < OUT_NUM; i++) shadow[i] <= '0;
    end else begin
      dataEnQ <= dataEn;

      if (cmdWr) begin
        outEn      <= dataIn[CMD_OUT_EN];
        autoCommit <= dataIn[CMD_AUTO_COMMIT];
      end

      if (cmdWr && dataIn[CMD_PTR_CLR]) ptr <= '0;
      else if (dataWr)                  ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;

      if (doCommit)       commitPending <= 1'b0;
      else if (commitSet) commitPending <= 1'b1;

      presc <= tick ? '0 : presc + 1'b1;
      if (tick) counter <= counter + 1'b1;

      for (int i = 0; i < OUT_NUM; i++) shadow[i] <= shadowNext[i];
    end
  end

  for (genvar gi = 0; gi < OUT_NUM; gi++) begin : gChan
    pwm_channel #(
      .C_WIDTH   (C_WIDTH),
      .PHASE_OFS (gi * PHASE_STEP)
    ) uChan (
      .clk     (clk),
      .reset   (reset),
      .load    (doCommit),
      .outEn   (outEn),
      .dutyIn  (shadowNext[gi]),
      .counter (counter),
      .pwmOut  (pwmOut[gi])
    );
  end

endmodule

// File: tb/tb_pwm_plane_driver.sv
// Directed scoreboard bench for pwm_plane_driver; one DUT at PRESCALE=1, one at PRESCALE=4.
module tb_pwm_plane_driver;
  import pwm_plane_driver_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] dataIn = '0;
  logic       dataEn = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] pwm1, pwm4;

  always #5 clk = ~clk;

  pwm_plane_driver #(.OUT_NUM(8), .D_WIDTH(8), .C_WIDTH(5), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .dataIn(dataIn), .dataEn(dataEn), .rs(rs), .pwmOut(pwm1));

  pwm_plane_driver #(.OUT_NUM(8), .D_WIDTH(8), .C_WIDTH(5), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .dataIn(dataIn), .dataEn(dataEn), .rs(rs), .pwmOut(pwm4));

  // Expected period position of dut1: advances one tick per clk from reset.
  logic [4:0] tbCnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) tbCnt <= '0;
    else        tbCnt <= tbCnt + 5'd1;
  end

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t       sbq[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         hiCnt[8];
  logic [7:0] acc;
  logic [7:0] samp[32];

  task automatic pushExp(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic popCheck(input int observed);
    exp_t e;
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", observed);
    end else begin
      e = sbq.pop_front();
      assert (observed === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, observed, e.val);
      end
    end
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    reset = 1'b0;
    dataEn = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wr(input logic isCmd, input logic [7:0] d, input int hold);
    @(negedge clk);
    rs = isCmd ? RS_CMD : RS_DATA;
    dataIn = d;
    dataEn = 1'b1;
    repeat (hold) @(negedge clk);
    dataEn = 1'b0;
    @(negedge clk);
  endtask

  task automatic orWin(input bit sel4, input int n);
    acc = '0;
    repeat (n) begin
      @(negedge clk);
      acc |= sel4 ? pwm4 : pwm1;
    end
  endtask

  task automatic dutyWin(input bit sel4, input int n);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) hiCnt[i] = 0;
    repeat (n) begin
      @(negedge clk);
      v = sel4 ? pwm4 : pwm1;
      for (int i = 0; i < 8; i++) if (v[i] === 1'b1) hiCnt[i]++;
    end
  endtask

  initial begin
    int shift, mism, g;

    // 1: reset held 10 clk, then idle for three periods
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    pushExp("reset_pwm1", 0);
    popCheck(int'(pwm1));
    pushExp("reset_pwm4", 0);
    popCheck(int'(pwm4));
    reset = 1'b1;
    pushExp("idle_3_periods", 0);
    orWin(1'b0, 96);
    popCheck(int'(acc));

    // 2: mixed duties, committed on the next wrap
    doReset(2);
    wr(1'b1, 8'h05, 1);
    wr(1'b0, 8'h00, 1);
    wr(1'b0, 8'h0F, 1);
    wr(1'b0, 8'h1F, 1);
    wr(1'b0, 8'h10, 1);
    wr(1'b1, 8'h06, 1);
    pushExp("pre_wrap_zero", 0);
    pushExp("t2_ch0", 0);
    pushExp("t2_ch1", 15);
    pushExp("t2_ch2", 31);
    pushExp("t2_ch3", 16);
    for (int i = 4; i < 8; i++) pushExp($sformatf("t2_ch%0d", i), 0);
    acc = '0;
    g = 0;
    while (tbCnt != 5'd0 && g < 64) begin
      acc |= pwm1;
      @(negedge clk);
      g++;
    end
    acc |= pwm1;
    popCheck(int'(acc));
    repeat (40) @(negedge clk);
    dutyWin(1'b0, 32);
    for (int i = 0; i < 8; i++) popCheck(hiCnt[i]);

    // 3: shadow writes without commit stay invisible; then commit; then output disable
    doReset(2);
    wr(1'b1, 8'h05, 1);
    repeat (8) wr(1'b0, 8'h1F, 1);
    pushExp("no_commit_zero", 0);
    orWin(1'b0, 96);
    popCheck(int'(acc));
    wr(1'b1, 8'h06, 1);
    for (int i = 0; i < 8; i++) pushExp($sformatf("t3_ch%0d", i), 31);
    repeat (40) @(negedge clk);
    dutyWin(1'b0, 32);
    for (int i = 0; i < 8; i++) popCheck(hiCnt[i]);
    pushExp("outen_off_1clk", 0);
    wr(1'b1, 8'h00, 1);
    popCheck(int'(pwm1));
    pushExp("outen_off_hold", 0);
    orWin(1'b0, 32);
    popCheck(int'(acc));

    // 4: nine writes wrap the pointer onto channel 0
    doReset(2);
    wr(1'b1, 8'h05, 1);
    for (int v = 1; v <= 9; v++) wr(1'b0, 8'(v), 1);
    wr(1'b1, 8'h06, 1);
    pushExp("t4_ch0", 9);
    for (int i = 1; i < 8; i++) pushExp($sformatf("t4_ch%0d", i), i + 1);
    repeat (40) @(negedge clk);
    dutyWin(1'b0, 32);
    for (int i = 0; i < 8; i++) popCheck(hiCnt[i]);

    // 5: held strobes, truncated bytes, auto-commit, prescaled period of 128 clk
    doReset(2);
    wr(1'b1, 8'h0D, 1);
    repeat (8) wr(1'b0, 8'hFF, 4);
    for (int i = 0; i < 8; i++) pushExp($sformatf("t5_auto_ch%0d", i), 124);
    repeat (300) @(negedge clk);
    dutyWin(1'b1, 128);
    for (int i = 0; i < 8; i++) popCheck(hiCnt[i]);
    wr(1'b0, 8'h03, 1);
    wr(1'b1, 8'h06, 1);
    pushExp("t5_ptr_ch0", 12);
    for (int i = 1; i < 8; i++) pushExp($sformatf("t5_ptr_ch%0d", i), 124);
    repeat (300) @(negedge clk);
    dutyWin(1'b1, 128);
    for (int i = 0; i < 8; i++) popCheck(hiCnt[i]);

    // 6: channel phase relation at duty 16, then reset mid-period
    doReset(2);
    wr(1'b1, 8'h05, 1);
    repeat (8) wr(1'b0, 8'h10, 1);
    wr(1'b1, 8'h06, 1);
    repeat (40) @(negedge clk);
    for (int t = 0; t < 32; t++) begin
      @(negedge clk);
      samp[t] = pwm1;
    end
    mism = 0;
    for (int t = 0; t < 32; t++) if (samp[t][0] === 1'b1) mism++;
    pushExp("t6_ch0_duty", 16);
    popCheck(mism);
    for (int i = 1; i < 8; i++) begin
`ifdef PWM_PHASE_SHIFT_EN
      shift = 4 * i;
`else
      shift = 0;
`endif
      mism = 0;
      for (int t = 0; t < 32; t++)
        if (samp[t][i] !== samp[(t + shift) % 32][0]) mism++;
      pushExp($sformatf("t6_phase_ch%0d", i), 0);
      popCheck(mism);
    end
    g = 0;
    while (pwm1[0] !== 1'b1 && g < 64) begin
      @(negedge clk);
      g++;
    end
    pushExp("t6_high_before_reset", 1);
    popCheck(int'(pwm1[0]));
    #2 reset = 1'b0;
    #1;
    pushExp("t6_reset_kill", 0);
    popCheck(int'(pwm1));
    @(negedge clk);
    reset = 1'b1;
    wr(1'b1, 8'h06, 1);
    pushExp("t6_banks_cleared", 0);
    repeat (40) @(negedge clk);
    orWin(1'b0, 32);
    popCheck(int'(acc));

    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
